// File: rtl/shift_arbiter.sv
// shift_arbiter: eight-way round-robin arbiter in front of one shared right shifter.
// Optional macro SHIFT_ARBITER_SHAMT_MASK_EN limits the shift amount to its low log2(WIDTH) bits.
module shift_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         req_valid,
    output logic [7:0]         req_ready,
    input  logic [8*WIDTH-1:0] req_data,
    input  logic [8*WIDTH-1:0] req_shamt,
    input  logic [7:0]         req_arith,
    output logic [7:0]         grant,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [WIDTH-1:0]   resp_data,
    output logic [2:0]         resp_id,
    output logic               busy
);
    localparam int LG = $clog2(WIDTH);
`ifdef SHIFT_ARBITER_SHAMT_MASK_EN
    localparam bit CLAMP = 1'b0;
`else
    localparam bit CLAMP = 1'b1;
`endif

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [WIDTH-1:0] shamt;
        logic             arith;
    } op_t;

    state_t          state, state_nxt;
    op_t [7:0]       lane_op;
    op_t             op;
    logic [2:0]      ptr, win_id, op_id;
    logic            win_vld, accept;
    logic [LG-1:0]   sh;
    logic            over, sign;
    logic [WIDTH-1:0] shifted, fill, result;

    for (genvar i = 0; i < 8; i++) begin : g_lane
        assign lane_op[i] = {req_data[i*WIDTH +: WIDTH], req_shamt[i*WIDTH +: WIDTH], req_arith[i]};
    end

    // Scan from the farthest offset down so the nearest valid requester to ptr wins.
    always_comb begin
        win_vld = 1'b0;
        win_id  = ptr;
        for (int k = 7; k >= 0; k--) begin
            if (req_valid[ptr + 3'(k)]) begin
                win_vld = 1'b1;
                win_id  = ptr + 3'(k);
            end
        end
    end

    assign accept    = (state == IDLE) && win_vld && !reset;
    assign req_ready = accept ? (8'b1 << win_id) : 8'b0;

    always_comb begin
        state_nxt  = state;
        resp_valid = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: if (win_vld) state_nxt = EXEC;
            EXEC: begin
                busy      = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                busy       = 1'b1;
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Arithmetic fill ORs in the bits vacated by the shift when the operand MSB is set.
    always_comb begin
        sh      = op.shamt[LG-1:0];
        over    = CLAMP & (|op.shamt[WIDTH-1:LG]);
        sign    = op.arith & op.data[WIDTH-1];
        shifted = op.data >> sh;
        fill    = ~({WIDTH{1'b1}} >> sh);
        result  = sign ? (shifted | fill) : shifted;
        if (over) result = {WIDTH{sign}};
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            grant     <= '0;
            op        <= '0;
            op_id     <= '0;
            resp_data <= '0;
            resp_id   <= '0;
        end else begin
            if (accept) begin
                op    <= lane_op[win_id];
                op_id <= win_id;
                grant <= req_ready;
                ptr   <= win_id + 3'd1;
            end
            if (state == EXEC) begin
                resp_data <= result;
                resp_id   <= op_id;
            end
            if (state == RESP && resp_ready) grant <= '0;
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: reset, latency, round-robin order, backpressure,
// large shifts, drop-before-grant and reset during a response.
module tb_shift_arbiter;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic [7:0]     req_valid;
    logic [7:0]     req_ready;
    logic [8*W-1:0] req_data;
    logic [8*W-1:0] req_shamt;
    logic [7:0]     req_arith;
    logic [7:0]     grant;
    logic           resp_valid;
    logic           resp_ready;
    logic [W-1:0]   resp_data;
    logic [2:0]     resp_id;
    logic           busy;

    int checks = 0;
    int errors = 0;

    shift_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_shamt(req_shamt), .req_arith(req_arith),
        .grant(grant), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_id(resp_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] d, input logic [31:0] s, input logic a);
        req_data[i*W +: W]  = d;
        req_shamt[i*W +: W] = s;
        req_arith[i]        = a;
    endtask

    initial begin
        reset = 1'b1; req_valid = 8'hFF; resp_ready = 1'b1;
        req_data = '0; req_shamt = '0; req_arith = '0;
        #1;
        chk("ready_in_reset", 32'(req_ready), 32'h0);
        cyc(); #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_data", resp_data, 32'h0);
        chk("rst_resp_id", 32'(resp_id), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("ready_in_reset2", 32'(req_ready), 32'h0);

        // Single request to requester 2, arithmetic shift by 4.
        reset = 1'b0; req_valid = 8'h00;
        cyc();
        req_valid = 8'b0000_0100; set_req(2, 32'hF000_0000, 32'd4, 1'b1);
        #1;
        chk("single_ready", 32'(req_ready), 32'h04);
        cyc(); req_valid = 8'h00; #1;
        chk("single_exec_busy", 32'(busy), 32'h1);
        chk("single_exec_rv", 32'(resp_valid), 32'h0);
        chk("single_exec_grant", 32'(grant), 32'h04);
        chk("single_exec_ready", 32'(req_ready), 32'h0);
        cyc(); #1;
        chk("single_rv", 32'(resp_valid), 32'h1);
        chk("single_data", resp_data, 32'hFF00_0000);
        chk("single_id", 32'(resp_id), 32'h2);
        cyc(); #1;
        chk("single_idle_busy", 32'(busy), 32'h0);
        chk("single_idle_grant", 32'(grant), 32'h0);

        // Reset brings ptr back to 0 before the fairness run.
        reset = 1'b1; cyc(); reset = 1'b0;
        for (int i = 0; i < 8; i++) set_req(i, 32'h0000_0100 << i, 32'd0, 1'b0);
        req_valid = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            #1;
            chk("rr_ready", 32'(req_ready), 32'(8'b1 << (k % 8)));
            cyc(); #1;
            chk("rr_exec_ready", 32'(req_ready), 32'h0);
            cyc(); #1;
            chk("rr_rv", 32'(resp_valid), 32'h1);
            chk("rr_id", 32'(resp_id), 32'(k % 8));
            chk("rr_data", resp_data, 32'h0000_0100 << (k % 8));
            cyc();
        end

        // ptr is now 1: requester 1 wins over 0; 0 then withdraws during EXEC.
        req_valid = 8'b0000_0011; set_req(1, 32'h1234_5678, 32'd8, 1'b1);
        #1;
        chk("drop_ready", 32'(req_ready), 32'h02);
        cyc(); req_valid = 8'h00; #1;
        chk("drop_exec_ready", 32'(req_ready), 32'h0);
        cyc(); #1;
        chk("drop_rv", 32'(resp_valid), 32'h1);
        chk("drop_id", 32'(resp_id), 32'h1);
        chk("drop_data", resp_data, 32'h0012_3456);
        cyc(); #1;
        chk("drop_idle_ready", 32'(req_ready), 32'h0);
        chk("drop_idle_busy", 32'(busy), 32'h0);

        // Backpressure on requester 7 while requester 0 waits.
        set_req(7, 32'hA5A5_0000, 32'd16, 1'b1);
        set_req(0, 32'h8000_0001, 32'd33, 1'b0);
        set_req(1, 32'h8000_0001, 32'd33, 1'b1);
        req_valid = 8'h80; resp_ready = 1'b0;
        #1;
        chk("bp_ready", 32'(req_ready), 32'h80);
        cyc(); req_valid = 8'h01; #1;
        cyc(); #1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_rv", 32'(resp_valid), 32'h1);
            chk("bp_data", resp_data, 32'hFFFF_A5A5);
            chk("bp_id", 32'(resp_id), 32'h7);
            chk("bp_ready_hold", 32'(req_ready), 32'h0);
            cyc(); #1;
        end
        resp_ready = 1'b1; #1;
        chk("bp_last_rv", 32'(resp_valid), 32'h1);
        chk("bp_last_ready", 32'(req_ready), 32'h0);
        cyc(); #1;
        chk("bp_resume_ready", 32'(req_ready), 32'h01);

        // Large shift amounts (33) on requesters 0 (logical) and 1 (arithmetic).
        cyc(); req_valid = 8'h02; #1;
        cyc(); #1;
        chk("big_log_id", 32'(resp_id), 32'h0);
`ifdef SHIFT_ARBITER_SHAMT_MASK_EN
        chk("big_log_data", resp_data, 32'h4000_0000);
`else
        chk("big_log_data", resp_data, 32'h0000_0000);
`endif
        cyc(); #1;
        chk("big_arith_ready", 32'(req_ready), 32'h02);
        cyc(); req_valid = 8'h00; #1;
        cyc(); #1;
        chk("big_arith_id", 32'(resp_id), 32'h1);
`ifdef SHIFT_ARBITER_SHAMT_MASK_EN
        chk("big_arith_data", resp_data, 32'hC000_0000);
`else
        chk("big_arith_data", resp_data, 32'hFFFF_FFFF);
`endif

        // Reset while holding a response; ptr (now 2) must return to 0.
        cyc();
        set_req(4, 32'h0000_00F0, 32'd4, 1'b0);
        req_valid = 8'h10; resp_ready = 1'b0;
        #1;
        chk("rr_resp_ready", 32'(req_ready), 32'h10);
        cyc(); req_valid = 8'h00; #1;
        cyc(); #1;
        chk("rst_resp_rv_pre", 32'(resp_valid), 32'h1);
        reset = 1'b1; req_valid = 8'h81; #1;
        chk("rst_resp_ready_gated", 32'(req_ready), 32'h0);
        cyc(); reset = 1'b0; #1;
        chk("rst_resp_rv", 32'(resp_valid), 32'h0);
        chk("rst_resp_busy", 32'(busy), 32'h0);
        chk("rst_resp_grant", 32'(grant), 32'h0);
        chk("rst_resp_first", 32'(req_ready), 32'h01);
        cyc(); req_valid = 8'h00; #1;
        chk("rst_resp_grant0", 32'(grant), 32'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
